// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: takes a word over valid/ready, shifts L bits full-duplex with a
// shift_en strobe every DIV cycles, then returns captured bits over valid/ready.
module shift_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [$clog2(WIDTH+1)-1:0]   in_len,
    input  logic                         abort,
    input  logic                         sin,
    output logic                         sout,
    output logic                         shift_en,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  tx_q;
    logic [WIDTH-1:0]  rx_q;
    logic [LW-1:0]     cnt_q;
    logic [DW-1:0]     div_q;
    logic              in_ready_q;
    logic              sout_q;
    logic              shift_en_q;
    logic              busy_q;
    logic              out_valid_q;

    logic [LW-1:0]     len_d;
    logic [WIDTH-1:0]  tx_load_d;
    logic [WIDTH-1:0]  tx_step_d;
    logic [DW-1:0]     div_d;

    // The transmit register always presents the current bit at its head end.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        len_d = in_len;
        if (in_len == '0 || in_len > LW'(WIDTH))
            len_d = LW'(WIDTH);
        // MSB-first left-aligns so bit L-1 sits at the head position.
        tx_load_d = (MSB_FIRST != 0) ? (in_data << (LW'(WIDTH) - len_d)) : in_data;
        tx_step_d = (MSB_FIRST != 0) ? (tx_q << 1) : (tx_q >> 1);
        div_d     = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            in_ready_q  <= 1'b1;
            sout_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            in_ready_q  <= 1'b1;
            sout_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= SHIFT;
                        tx_q       <= tx_load_d;
                        rx_q       <= '0;
                        cnt_q      <= len_d;
                        div_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        sout_q     <= head(tx_load_d);
                        shift_en_q <= (DIV == 1);
                    end
                end
                SHIFT: begin
                    div_q      <= div_d;
                    shift_en_q <= (div_d == DW'(DIV - 1));
                    if (shift_en_q) begin
                        rx_q  <= {rx_q[WIDTH-2:0], sin};
                        tx_q  <= tx_step_d;
                        cnt_q <= cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            state_q     <= HOLD;
                            sout_q      <= 1'b0;
                            shift_en_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            sout_q <= head(tx_step_d);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sout      = sout_q;
    assign shift_en  = shift_en_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = rx_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: instance 0 is DIV=1 LSB-first, instance 1 is DIV=3 MSB-first.
module tb_shift_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] in_data   [2];
    logic [2:0] in_len    [2];
    logic       abort     [2];
    logic       sin       [2];
    logic       sout      [2];
    logic       shift_en  [2];
    logic       busy      [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] out_data  [2];

    int nvec = 0;
    int nmis = 0;

    shift_seq_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_len(in_len[0]), .abort(abort[0]), .sin(sin[0]), .sout(sout[0]),
        .shift_en(shift_en[0]), .busy(busy[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0])
    );

    shift_seq_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_len(in_len[1]), .abort(abort[1]), .sin(sin[1]), .sout(sout[1]),
        .shift_en(shift_en[1]), .busy(busy[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Transmitted bit for step j, straight from the ordering rule.
    function automatic logic tx_bit(input int k, input logic [3:0] d, input int len, input int j);
        logic [3:0] v;
        v = d;
        return (k == 1) ? v[len-1-j] : v[j];
    endfunction

    // One transfer on instance k. ab>0 raises abort in that cycle after E0.
    task automatic xfer(input int k, input logic [3:0] d, input logic [2:0] len,
                        input bit loop, input logic [3:0] pat, input int rd, input int ab);
        int         L, D, total, waited, j;
        logic [3:0] cap, exp_od;
        logic [4:0] exp_v, obs_v;
        L = (len == 0 || len > 4) ? 4 : int'(len);
        D = div_of(k);
        total = L * D + 1 + rd;
        cap = '0;
        exp_od = '0;
        for (int i = 0; i < L; i++) begin
            cap[i] = loop ? tx_bit(k, d, L, i) : pat[i];
            exp_od[L-1-i] = cap[i];
        end

        waited = 0;
        @(negedge clk);
        while (in_ready[k] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        nvec++;
        if (in_ready[k] !== 1'b1) begin
            nmis++;
            $display("FAIL ready_timeout dut%0d: in_ready=%b after %0d cycles, required 1", k, in_ready[k], waited);
        end
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_len[k]   = len;
        @(posedge clk);
        #1 in_valid[k] = 1'b0;

        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            obs_v = {in_ready[k], busy[k], shift_en[k], sout[k], out_valid[k]};
            if (n <= L * D) begin
                j = (n - 1) / D;
                exp_v = {1'b0, 1'b1, (n % D == 0), tx_bit(k, d, L, j), 1'b0};
                sin[k] = loop ? sout[k] : pat[j];
            end else begin
                exp_v = 5'b01001;
                nvec++;
                if (out_data[k] !== exp_od) begin
                    nmis++;
                    $display("FAIL out_data dut%0d cyc%0d: got %b, required %b", k, n, out_data[k], exp_od);
                end
            end
            nvec++;
            if (obs_v !== exp_v) begin
                nmis++;
                $display("FAIL cycle dut%0d cyc%0d {rdy,busy,sen,sout,ov}: got %b, required %b", k, n, obs_v, exp_v);
            end
            if (n == ab) begin
                abort[k] = 1'b1;
                @(negedge clk);
                abort[k] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    obs_v = {in_ready[k], busy[k], shift_en[k], sout[k], out_valid[k]};
                    nvec++;
                    if (obs_v !== 5'b10000) begin
                        nmis++;
                        $display("FAIL post_abort dut%0d +%0d: got %b, required 10000", k, c, obs_v);
                    end
                    @(negedge clk);
                end
                return;
            end
            if (n == total) out_ready[k] = 1'b1;
        end
        @(negedge clk);
        out_ready[k] = 1'b0;
        obs_v = {in_ready[k], busy[k], shift_en[k], sout[k], out_valid[k]};
        nvec++;
        if (obs_v !== 5'b10000) begin
            nmis++;
            $display("FAIL after_handshake dut%0d: got %b, required 10000", k, obs_v);
        end
    endtask

    task automatic check_idle_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if ({in_ready[k], busy[k], shift_en[k], sout[k], out_valid[k], out_data[k]} !== 9'b100000000) begin
                nmis++;
                $display("FAIL %s dut%0d: got rdy=%b busy=%b sen=%b sout=%b ov=%b od=%b, required 1 0 0 0 0 0000",
                         tag, k, in_ready[k], busy[k], shift_en[k], sout[k], out_valid[k], out_data[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12 check_idle_all("reset_asserted");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check_idle_all("reset_released");
    endtask

    task automatic test_loopback_lsb();
        xfer(0, 4'b1011, 3'd4, 1'b1, 4'b0000, 0, 0);
    endtask

    task automatic test_div_msb();
        xfer(1, 4'b1001, 3'd4, 1'b0, 4'b1111, 0, 0);
    endtask

    task automatic test_hold_backpressure();
        xfer(0, 4'b0110, 3'd2, 1'b0, 4'b0001, 10, 0);
        xfer(1, 4'b0101, 3'd2, 1'b0, 4'b0001, 10, 0);
    endtask

    task automatic test_abort();
        xfer(0, 4'b1110, 3'd4, 1'b0, 4'b1010, 0, 2);
        xfer(0, 4'b0011, 3'd4, 1'b0, 4'b0110, 0, 0);
        xfer(1, 4'b1100, 3'd3, 1'b0, 4'b0101, 2, 11);
    endtask

    task automatic test_abort_priority();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_len[0]   = 3'd0;
        in_data[0]  = 4'b1111;
        abort[0]    = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        abort[0]    = 1'b0;
        nvec++;
        if ({in_ready[0], busy[0], shift_en[0]} !== 3'b100) begin
            nmis++;
            $display("FAIL abort_priority: got rdy/busy/sen=%b%b%b, required 100", in_ready[0], busy[0], shift_en[0]);
        end
        xfer(0, 4'b1010, 3'd0, 1'b0, 4'b1001, 1, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 4'b1111;
        in_len[1]   = 3'd4;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            nvec++;
            if (out_valid[1] !== 1'b0 || shift_en[1] !== 1'b0) begin
                nmis++;
                $display("FAIL after_reset_quiet +%0d: ov=%b sen=%b, required 0 0", c, out_valid[1], shift_en[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int k, ab;
            k  = $urandom_range(0, 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * div_of(k) + 2) : 0;
            xfer(k, 4'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 4'($urandom), $urandom_range(0, 3), ab);
        end
    endtask

    task automatic test_back_to_back();
        xfer(0, 4'b0101, 3'd1, 1'b0, 4'b0001, 0, 0);
        xfer(0, 4'b1100, 3'd3, 1'b1, 4'b0000, 0, 0);
        xfer(1, 4'b0010, 3'd1, 1'b0, 4'b0001, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_len[k]    = '0;
            abort[k]     = 1'b0;
            sin[k]       = 1'b0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b1;
        #1;
        test_reset();
        test_loopback_lsb();
        test_div_msb();
        test_hold_backpressure();
        test_abort();
        test_abort_priority();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
